// File: rtl/scan_addr_gen_if.sv
// Handshake bundle between a scan controller and the address sequencer.
// The master issues commands; the slave returns the decoder address and status.
interface scan_addr_gen_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic               A;
    logic               B;
    logic               C;
    logic               en;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mode, dwell,
        input  A, B, C, en, busy, done
    );

    modport slave (
        input  start, stop, mode, dwell,
        output A, B, C, en, busy, done
    );
endinterface

// File: rtl/scan_addr_gen.sv
// Registered sweep sequencer for the 3-to-8 decoder select lines.
// Holds each address 0..7 for a latched dwell; single or continuous sweeps.
module scan_addr_gen #(
    parameter int DWELL_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    scan_addr_gen_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [2:0]         addr;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] d_lat;
    logic               m_lat;
    logic               en;
    logic               busy;
    logic               done;
    logic               dwell_end;

    // Last cycle of the current address hold; cnt never passes d_lat-1.
    assign dwell_end = (cnt == d_lat - DWELL_W'(1));

    assign bus.A    = addr[2];
    assign bus.B    = addr[1];
    assign bus.C    = addr[0];
    assign bus.en   = en;
    assign bus.busy = busy;
    assign bus.done = done;

    // Sequencer state, address, dwell counter and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= 3'd0;
            cnt   <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d_lat <= DWELL_W'(1);
            m_lat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    addr <= 3'd0;
                    cnt  <= '0;
                    en   <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        state <= SCAN;
                        en    <= 1'b1;
                        busy  <= 1'b1;
                        m_lat <= bus.mode;
                        d_lat <= (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                    end
                end
                SCAN: begin
                    done <= 1'b0;
                    if (bus.stop) begin
                        state <= IDLE;
                        addr  <= 3'd0;
                        cnt   <= '0;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end else if (!dwell_end) begin
                        cnt <= cnt + DWELL_W'(1);
                    end else begin
                        cnt <= '0;
                        if (addr != 3'd7) begin
                            addr <= addr + 3'd1;
                        end else if (!m_lat) begin
                            state <= DONE;
                            addr  <= 3'd0;
                            en    <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            addr <= 3'd0;
                            done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    addr  <= 3'd0;
                    cnt   <= '0;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    addr  <= 3'd0;
                    cnt   <= '0;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
